// File: rtl/bram_port_arbiter_if.sv
// Request/response/BRAM-side bundle for bram_port_arbiter.
// slave = arbiter side, master = client + BRAM side.
interface bram_port_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              req0_valid;
    logic              req0_ready;
    logic              req0_we;
    logic              req0_lock;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;

    logic              req1_valid;
    logic              req1_ready;
    logic              req1_we;
    logic              req1_lock;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;

    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic [DATA_W-1:0] bram_dout;
    logic              grant_id;

    modport slave (
        input  req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
        input  bram_dout,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output bram_we, bram_addr, bram_din, grant_id
    );

    modport master (
        output req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
        output bram_dout,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  bram_we, bram_addr, bram_din, grant_id
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter with bounded burst lock sharing BRAM port A between two requesters.
// Optional grant statistics counters: define ARB_STATS_EN.
module bram_port_arbiter #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4,
    parameter int BCNT_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    bram_port_arbiter_if.slave bus
`ifdef ARB_STATS_EN
    ,
    input  logic               stat_clr,
    output logic [15:0]        gnt0_cnt,
    output logic [15:0]        gnt1_cnt
`endif
);

    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    localparam logic [BCNT_W:0] LP_MAX_BURST = (BCNT_W+1)'(MAX_BURST);
    localparam logic            LP_LOCK_EN   = (MAX_BURST > 1);

    generate
        if (MAX_BURST < 1 || (2**BCNT_W) < MAX_BURST) begin : g_cfg_check
            $error("bram_port_arbiter: MAX_BURST must be >=1 and fit in BCNT_W bits");
        end
    endgenerate

    state_t            r_state, w_state_nxt;
    logic              r_last_grant, w_last_grant_nxt;
    logic [BCNT_W-1:0] r_burst_cnt, w_burst_cnt_nxt;
    logic [BCNT_W:0]   w_cnt_inc;
    logic              r_rsp0_valid, r_rsp1_valid;
    logic              w_gnt0, w_gnt1, w_arb_open;
    logic              w_win_we, w_win_lock;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_din;

    // An owner that drops valid gives up the lock in the same cycle, so the
    // other requester can be granted right away instead of stalling a cycle.
    always_comb begin : p_grant
        w_gnt0     = 1'b0;
        w_gnt1     = 1'b0;
        w_arb_open = 1'b0;
        case (r_state)
            OWN0:    if (bus.req0_valid) w_gnt0 = 1'b1; else w_arb_open = 1'b1;
            OWN1:    if (bus.req1_valid) w_gnt1 = 1'b1; else w_arb_open = 1'b1;
            default: w_arb_open = 1'b1;
        endcase
        if (w_arb_open) begin
            if (bus.req0_valid && bus.req1_valid) begin
                w_gnt0 = r_last_grant;
                w_gnt1 = ~r_last_grant;
            end else begin
                w_gnt0 = bus.req0_valid;
                w_gnt1 = bus.req1_valid;
            end
        end
        if (!rst_n) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    always_comb begin : p_bram_mux
        w_win_we   = 1'b0;
        w_win_lock = 1'b0;
        w_addr     = '0;
        w_din      = '0;
        if (w_gnt1) begin
            w_win_we   = bus.req1_we;
            w_win_lock = bus.req1_lock;
            w_addr     = bus.req1_addr;
            w_din      = bus.req1_wdata;
        end else if (w_gnt0) begin
            w_win_we   = bus.req0_we;
            w_win_lock = bus.req0_lock;
            w_addr     = bus.req0_addr;
            w_din      = bus.req0_wdata;
        end
    end

    always_comb begin : p_next
        w_state_nxt      = IDLE;
        w_burst_cnt_nxt  = '0;
        w_last_grant_nxt = r_last_grant;
        w_cnt_inc        = {1'b0, r_burst_cnt} + 1'b1;
        if (w_gnt0 || w_gnt1) begin
            w_last_grant_nxt = w_gnt1;
            if (w_arb_open) begin
                if (w_win_lock && LP_LOCK_EN) begin
                    w_state_nxt     = w_gnt1 ? OWN1 : OWN0;
                    w_burst_cnt_nxt = BCNT_W'(1);
                end
            end else if (w_win_lock && (w_cnt_inc != LP_MAX_BURST)) begin
                w_state_nxt     = r_state;
                w_burst_cnt_nxt = w_cnt_inc[BCNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_state
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_burst_cnt  <= '0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_burst_cnt  <= w_burst_cnt_nxt;
            r_rsp0_valid <= w_gnt0 & ~bus.req0_we;
            r_rsp1_valid <= w_gnt1 & ~bus.req1_we;
        end
    end

    assign bus.req0_ready = w_gnt0;
    assign bus.req1_ready = w_gnt1;
    assign bus.grant_id   = w_gnt1;
    assign bus.bram_we    = w_win_we;
    assign bus.bram_addr  = w_addr;
    assign bus.bram_din   = w_din;
    assign bus.rsp0_valid = r_rsp0_valid;
    assign bus.rsp1_valid = r_rsp1_valid;
    assign bus.rsp0_rdata = bus.bram_dout;
    assign bus.rsp1_rdata = bus.bram_dout;

`ifdef ARB_STATS_EN
    logic [15:0] r_gnt0_cnt, r_gnt1_cnt;

    always_ff @(posedge clk or negedge rst_n) begin : p_stats
        if (!rst_n) begin
            r_gnt0_cnt <= '0;
            r_gnt1_cnt <= '0;
        end else if (stat_clr) begin
            r_gnt0_cnt <= '0;
            r_gnt1_cnt <= '0;
        end else begin
            if (w_gnt0 && (r_gnt0_cnt != '1)) r_gnt0_cnt <= r_gnt0_cnt + 1'b1;
            if (w_gnt1 && (r_gnt1_cnt != '1)) r_gnt1_cnt <= r_gnt1_cnt + 1'b1;
        end
    end

    assign gnt0_cnt = r_gnt0_cnt;
    assign gnt1_cnt = r_gnt1_cnt;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: vector table, directed burst/reset sequences,
// and randomized traffic checked against a beat-level reference model.
module tb_bram_port_arbiter;
    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;
    localparam int BCNT_W    = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

`ifdef ARB_STATS_EN
    logic        stat_clr;
    logic [15:0] gnt0_cnt, gnt1_cnt;
`endif

    bram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .BCNT_W(BCNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
`ifdef ARB_STATS_EN
        ,
        .stat_clr(stat_clr),
        .gnt0_cnt(gnt0_cnt),
        .gnt1_cnt(gnt1_cnt)
`endif
    );

    // BRAM port A: synchronous write, 1-cycle registered read
    logic [DATA_W-1:0] bram_mem [2**ADDR_W];
    always @(posedge clk) begin
        if (bif.bram_we) bram_mem[bif.bram_addr] <= bif.bram_din;
        bif.bram_dout <= bram_mem[bif.bram_addr];
    end

    int checks = 0;
    int failures = 0;

    // reference model state
    int          m_last, m_owner, m_beats, m_g, m_rsp_id;
    logic [7:0]  m_rsp_data;
    bit          m_rsp_known;
    logic [7:0]  ref_mem [16];
    bit          ref_known [16];

    typedef struct {
        bit         bubble;
        bit         we;
        bit         lock;
        logic [3:0] addr;
        logic [7:0] data;
    } beat_t;
    beat_t q0[$], q1[$];
    int    trace[$];
    bit    s_rdy0, s_rdy1;

    typedef struct {
        bit rst_n;
        bit v0; bit we0; bit lk0; logic [3:0] a0; logic [7:0] d0;
        bit v1; bit we1; bit lk1; logic [3:0] a1; logic [7:0] d1;
        bit e_rdy0; bit e_rdy1; bit e_we; bit e_rsp0; bit e_rsp1; logic [7:0] e_rdata;
    } vec_t;
    vec_t vt[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void reset_model();
        m_owner  = -1;
        m_last   = 1;
        m_beats  = 0;
        m_rsp_id = -1;
    endfunction

    function automatic int predict();
        if (m_owner == 0 && bif.req0_valid) return 0;
        if (m_owner == 1 && bif.req1_valid) return 1;
        if (bif.req0_valid && bif.req1_valid) return (m_last == 0) ? 1 : 0;
        if (bif.req0_valid) return 0;
        if (bif.req1_valid) return 1;
        return -1;
    endfunction

    task automatic check_phase();
        logic       e_we;
        logic [3:0] e_addr;
        logic [7:0] e_din;
        @(negedge clk);
        if (!rst_n) begin
            reset_model();
            m_g = -1;
        end else begin
            m_g = predict();
        end
        s_rdy0 = bif.req0_ready;
        s_rdy1 = bif.req1_ready;
        if (bif.req0_ready) trace.push_back(0);
        if (bif.req1_ready) trace.push_back(1);
        e_we   = (m_g == 0) ? bif.req0_we    : (m_g == 1) ? bif.req1_we    : 1'b0;
        e_addr = (m_g == 0) ? bif.req0_addr  : bif.req1_addr;
        e_din  = (m_g == 0) ? bif.req0_wdata : bif.req1_wdata;
        chk("ready0", 32'(bif.req0_ready), 32'(m_g == 0));
        chk("ready1", 32'(bif.req1_ready), 32'(m_g == 1));
        chk("bram_we", 32'(bif.bram_we), 32'(e_we));
        if (m_g >= 0) begin
            chk("grant_id", 32'(bif.grant_id), 32'(m_g));
            chk("bram_addr", 32'(bif.bram_addr), 32'(e_addr));
            if (e_we) chk("bram_din", 32'(bif.bram_din), 32'(e_din));
        end
        if (!rst_n) begin
            chk("rst_bram_addr", 32'(bif.bram_addr), 32'd0);
            chk("rst_bram_din", 32'(bif.bram_din), 32'd0);
        end
        chk("rsp0_valid", 32'(bif.rsp0_valid), 32'(m_rsp_id == 0));
        chk("rsp1_valid", 32'(bif.rsp1_valid), 32'(m_rsp_id == 1));
        if (m_rsp_id == 0 && m_rsp_known) chk("rsp0_rdata", 32'(bif.rsp0_rdata), 32'(m_rsp_data));
        if (m_rsp_id == 1 && m_rsp_known) chk("rsp1_rdata", 32'(bif.rsp1_rdata), 32'(m_rsp_data));
    endtask

    task automatic advance();
        bit         we, lk;
        logic [3:0] a;
        logic [7:0] d;
        @(posedge clk);
        if (rst_n) begin
            m_rsp_id = -1;
            if (m_g >= 0) begin
                we = (m_g == 0) ? bif.req0_we    : bif.req1_we;
                lk = (m_g == 0) ? bif.req0_lock  : bif.req1_lock;
                a  = (m_g == 0) ? bif.req0_addr  : bif.req1_addr;
                d  = (m_g == 0) ? bif.req0_wdata : bif.req1_wdata;
                if (we) begin
                    ref_mem[a]   = d;
                    ref_known[a] = 1'b1;
                end else begin
                    m_rsp_id    = m_g;
                    m_rsp_data  = ref_mem[a];
                    m_rsp_known = ref_known[a];
                end
                if (m_owner == m_g) begin
                    m_beats++;
                    if (!lk || m_beats == MAX_BURST) m_owner = -1;
                end else begin
                    m_last = m_g;
                    if (lk && MAX_BURST > 1) begin
                        m_owner = m_g;
                        m_beats = 1;
                    end else begin
                        m_owner = -1;
                    end
                end
            end else begin
                m_owner = -1;
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        bif.req0_valid = 0; bif.req0_we = 0; bif.req0_lock = 0; bif.req0_addr = '0; bif.req0_wdata = '0;
        bif.req1_valid = 0; bif.req1_we = 0; bif.req1_lock = 0; bif.req1_addr = '0; bif.req1_wdata = '0;
    endtask

    task automatic idle(input int n);
        clear_inputs();
        for (int i = 0; i < n; i++) begin
            check_phase();
            advance();
        end
    endtask

    task automatic apply_queues();
        clear_inputs();
        if (q0.size() > 0 && !q0[0].bubble) begin
            bif.req0_valid = 1; bif.req0_we = q0[0].we; bif.req0_lock = q0[0].lock;
            bif.req0_addr = q0[0].addr; bif.req0_wdata = q0[0].data;
        end
        if (q1.size() > 0 && !q1[0].bubble) begin
            bif.req1_valid = 1; bif.req1_we = q1[0].we; bif.req1_lock = q1[0].lock;
            bif.req1_addr = q1[0].addr; bif.req1_wdata = q1[0].data;
        end
    endtask

    task automatic run_queues(input int max_cycles);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < max_cycles) begin
            apply_queues();
            check_phase();
            advance();
            if (q0.size() > 0 && (q0[0].bubble || s_rdy0)) void'(q0.pop_front());
            if (q1.size() > 0 && (q1[0].bubble || s_rdy1)) void'(q1.pop_front());
            n++;
        end
        chk("queue_drain_left", 32'(q0.size() + q1.size()), 32'd0);
        q0.delete();
        q1.delete();
        clear_inputs();
    endtask

    task automatic check_trace(input string name, input int exp[$]);
        chk({name, "_len"}, 32'(trace.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            if (i < trace.size()) chk($sformatf("%s[%0d]", name, i), 32'(trace[i]), 32'(exp[i]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_q[$];
        beat_t b;
        rst_n = 1'b0;
        clear_inputs();
`ifdef ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        for (int i = 0; i < 16; i++) ref_known[i] = 1'b0;
        reset_model();
        m_g = -1;

        // reset state
        bif.req0_valid = 1; bif.req1_valid = 1;
        check_phase();
`ifdef ARB_STATS_EN
        chk("rst_gnt0_cnt", 32'(gnt0_cnt), 32'd0);
        chk("rst_gnt1_cnt", 32'(gnt1_cnt), 32'd0);
`endif
        advance();
        clear_inputs();
        rst_n = 1'b1;

        // writes AA/BB/CC from req0, read back by req1; then reset and a round-robin tie run
        vt[0]  = '{1, 1,1,0,4'h1,8'hAA, 0,0,0,4'h0,8'h00, 1,0,1,0,0,8'h00};
        vt[1]  = '{1, 1,1,0,4'h2,8'hBB, 0,0,0,4'h0,8'h00, 1,0,1,0,0,8'h00};
        vt[2]  = '{1, 1,1,0,4'h3,8'hCC, 0,0,0,4'h0,8'h00, 1,0,1,0,0,8'h00};
        vt[3]  = '{1, 0,0,0,4'h0,8'h00, 1,0,0,4'h1,8'h00, 0,1,0,0,0,8'h00};
        vt[4]  = '{1, 0,0,0,4'h0,8'h00, 1,0,0,4'h2,8'h00, 0,1,0,0,1,8'hAA};
        vt[5]  = '{1, 0,0,0,4'h0,8'h00, 1,0,0,4'h3,8'h00, 0,1,0,0,1,8'hBB};
        vt[6]  = '{1, 0,0,0,4'h0,8'h00, 0,0,0,4'h0,8'h00, 0,0,0,0,1,8'hCC};
        vt[7]  = '{1, 0,0,0,4'h0,8'h00, 0,0,0,4'h0,8'h00, 0,0,0,0,0,8'h00};
        vt[8]  = '{0, 1,0,0,4'h1,8'h00, 1,0,0,4'h2,8'h00, 0,0,0,0,0,8'h00};
        vt[9]  = '{1, 1,0,0,4'h1,8'h00, 1,0,0,4'h2,8'h00, 1,0,0,0,0,8'h00};
        vt[10] = '{1, 1,0,0,4'h1,8'h00, 1,0,0,4'h2,8'h00, 0,1,0,1,0,8'hAA};
        vt[11] = '{1, 1,0,0,4'h1,8'h00, 1,0,0,4'h2,8'h00, 1,0,0,0,1,8'hBB};
        vt[12] = '{1, 1,0,0,4'h1,8'h00, 1,0,0,4'h2,8'h00, 0,1,0,1,0,8'hAA};
        vt[13] = '{1, 1,0,0,4'h1,8'h00, 1,0,0,4'h2,8'h00, 1,0,0,0,1,8'hBB};
        vt[14] = '{1, 1,0,0,4'h1,8'h00, 1,0,0,4'h2,8'h00, 0,1,0,1,0,8'hAA};
        vt[15] = '{1, 0,0,0,4'h0,8'h00, 0,0,0,4'h0,8'h00, 0,0,0,0,1,8'hBB};
        vt[16] = '{1, 0,0,0,4'h0,8'h00, 0,0,0,4'h0,8'h00, 0,0,0,0,0,8'h00};
        for (int i = 0; i < 17; i++) begin
            rst_n = vt[i].rst_n;
            bif.req0_valid = vt[i].v0; bif.req0_we = vt[i].we0; bif.req0_lock = vt[i].lk0;
            bif.req0_addr = vt[i].a0; bif.req0_wdata = vt[i].d0;
            bif.req1_valid = vt[i].v1; bif.req1_we = vt[i].we1; bif.req1_lock = vt[i].lk1;
            bif.req1_addr = vt[i].a1; bif.req1_wdata = vt[i].d1;
            check_phase();
            chk($sformatf("tbl%0d_ready0", i), 32'(bif.req0_ready), 32'(vt[i].e_rdy0));
            chk($sformatf("tbl%0d_ready1", i), 32'(bif.req1_ready), 32'(vt[i].e_rdy1));
            chk($sformatf("tbl%0d_bram_we", i), 32'(bif.bram_we), 32'(vt[i].e_we));
            chk($sformatf("tbl%0d_rsp0_valid", i), 32'(bif.rsp0_valid), 32'(vt[i].e_rsp0));
            chk($sformatf("tbl%0d_rsp1_valid", i), 32'(bif.rsp1_valid), 32'(vt[i].e_rsp1));
            if (vt[i].e_rsp0) chk($sformatf("tbl%0d_rsp0_rdata", i), 32'(bif.rsp0_rdata), 32'(vt[i].e_rdata));
            if (vt[i].e_rsp1) chk($sformatf("tbl%0d_rsp1_rdata", i), 32'(bif.rsp1_rdata), 32'(vt[i].e_rdata));
            advance();
        end
        rst_n = 1'b1;
        idle(2);

        // locked 6-beat write burst from req0 against a waiting req1 read
        trace.delete();
        for (int i = 0; i < 6; i++) q0.push_back('{1'b0, 1'b1, 1'b1, 4'(8 + i), 8'(8'h10 + i)});
        q1.push_back('{1'b0, 1'b0, 1'b0, 4'h3, 8'h00});
        run_queues(40);
        exp_q = {0, 0, 0, 0, 1, 0, 0};
        check_trace("burst_trace", exp_q);
        idle(2);

        // owner drops valid mid-lock: waiting requester gets the port in that cycle
        trace.delete();
        q0.push_back('{1'b0, 1'b1, 1'b1, 4'h4, 8'h5A});
        q0.push_back('{1'b1, 1'b0, 1'b0, 4'h0, 8'h00});
        q0.push_back('{1'b0, 1'b1, 1'b0, 4'h5, 8'hA5});
        q1.push_back('{1'b1, 1'b0, 1'b0, 4'h0, 8'h00});
        q1.push_back('{1'b0, 1'b0, 1'b0, 4'h4, 8'h00});
        run_queues(20);
        exp_q = {0, 1, 0};
        check_trace("drop_trace", exp_q);
        idle(2);

        // reset mid-burst with a read response pending
        bif.req0_valid = 1; bif.req0_we = 0; bif.req0_lock = 1; bif.req0_addr = 4'h1;
        check_phase();
        advance();
        rst_n = 1'b0;
        bif.req1_valid = 1; bif.req1_we = 0; bif.req1_addr = 4'h2;
        check_phase();
        chk("midrst_rsp0_valid", 32'(bif.rsp0_valid), 32'd0);
        chk("midrst_ready0", 32'(bif.req0_ready), 32'd0);
        advance();
        rst_n = 1'b1;
        bif.req0_lock = 0;
        check_phase();
        chk("postrst_tie_ready0", 32'(bif.req0_ready), 32'd1);
        chk("postrst_tie_grant", 32'(bif.grant_id), 32'd0);
        advance();
        idle(2);

        // randomized traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            b.bubble = ($urandom_range(0, 4) == 0);
            b.we = 1'($urandom_range(0, 1)); b.lock = 1'($urandom_range(0, 1));
            b.addr = 4'($urandom_range(0, 15)); b.data = 8'($urandom);
            q0.push_back(b);
            b.bubble = ($urandom_range(0, 4) == 0);
            b.we = 1'($urandom_range(0, 1)); b.lock = 1'($urandom_range(0, 1));
            b.addr = 4'($urandom_range(0, 15)); b.data = 8'($urandom);
            q1.push_back(b);
        end
        run_queues(1000);
        idle(2);

`ifdef ARB_STATS_EN
        stat_clr = 1'b1;
        check_phase();
        advance();
        stat_clr = 1'b0;
        for (int i = 0; i < 5; i++) q0.push_back('{1'b0, 1'b1, 1'b0, 4'(i), 8'(8'h30 + i)});
        for (int i = 0; i < 3; i++) q1.push_back('{1'b0, 1'b0, 1'b0, 4'(i), 8'h00});
        run_queues(40);
        check_phase();
        chk("stat_gnt0_cnt", 32'(gnt0_cnt), 32'd5);
        chk("stat_gnt1_cnt", 32'(gnt1_cnt), 32'd3);
        advance();
        stat_clr = 1'b1;
        check_phase();
        advance();
        stat_clr = 1'b0;
        check_phase();
        chk("stat_clr_gnt0_cnt", 32'(gnt0_cnt), 32'd0);
        chk("stat_clr_gnt1_cnt", 32'(gnt1_cnt), 32'd0);
        advance();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
